// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx scheduler and the byte-sender benches.
package uart_pkg;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_ISSUE = 3'd2,
    S_BUSY  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  localparam int unsigned START_DELAY_DEF = 500000;
  localparam int unsigned GAP_CYCLES_DEF  = 100000;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin selector: a locked owner wins outright, otherwise
// the first valid requester at or above the pointer, with wrap-around.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  input  logic             lock_i,
  input  logic [ID_W-1:0]  owner_i,
  output logic [ID_W-1:0]  sel_o,
  output logic             any_valid_o
);

  always_comb begin
    int unsigned idx;
    logic [ID_W-1:0] idx_w;
    idx         = 0;
    idx_w       = '0;
    sel_o       = owner_i;
    any_valid_o = 1'b0;
    if (lock_i) begin
      any_valid_o = req_i[owner_i];
    end else begin
      // Scan from the far end back to the pointer so the nearest hit wins.
      for (int unsigned k = N_REQ; k > 0; k--) begin
        idx = 32'(ptr_i) + k - 1;
        if (idx >= N_REQ) idx = idx - N_REQ;
        idx_w = ID_W'(idx);
        if (req_i[idx_w]) begin
          sel_o       = idx_w;
          any_valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx among N_REQ byte streams: packet-granular round-robin,
// power-up hold-off and a minimum idle gap after every byte.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned START_DELAY = START_DELAY_DEF,
  parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int unsigned ID_W        = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 locked
);

  state_e          state_q;
  logic [31:0]     cnt_q;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [7:0]      tx_data_q;
  logic            tx_start_q;
  logic [ID_W-1:0] grant_q;
  logic            locked_q;
  logic            seen_busy_q;

  logic [ID_W-1:0] sel;
  logic            any_valid;
  logic            xfer;
  logic [7:0]      sel_byte;
  logic            sel_last;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .lock_i      (locked_q),
    .owner_i     (grant_q),
    .sel_o       (sel),
    .any_valid_o (any_valid)
  );

  assign xfer = (state_q == S_IDLE) && any_valid;

  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == sel) begin
        sel_byte = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
    ptr_d     = (32'(sel) == N_REQ - 1) ? '0 : sel + ID_W'(1);
    req_ready = xfer ? (N_REQ'(1) << sel) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      grant_q     <= '0;
      locked_q    <= 1'b0;
      seen_busy_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_WAIT: begin
          if (START_DELAY == 0 || cnt_q == START_DELAY - 1) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_IDLE: begin
          if (xfer) begin
            tx_data_q  <= sel_byte;
            tx_start_q <= 1'b1;
            grant_q    <= sel;
            locked_q   <= ~sel_last;
            if (sel_last) ptr_q <= ptr_d;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          seen_busy_q <= 1'b0;
          state_q     <= S_BUSY;
        end
        S_BUSY: begin
          // A busy already high on entry counts as the rising edge.
          if (!seen_busy_q) begin
            if (tx_busy) seen_busy_q <= 1'b1;
          end else if (!tx_busy) begin
            seen_busy_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_CYCLES - 1) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: startup hold, round-robin, packet lock,
// owner stall, reset mid-byte, and a zero-gap build.
module tb_uart_tx_sched;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  req_valid = '0, req_last = '0, req_ready;
  logic [15:0] req_data  = '0;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy, locked;
  logic [0:0]  grant_id;

  logic [1:0]  zvalid = '0, zlast = '0, zready;
  logic [15:0] zdata  = '0;
  logic [7:0]  ztx_data;
  logic        zstart, zbusy, zlocked;
  logic [0:0]  zgrant;

  uart_tx_sched #(.N_REQ(2), .START_DELAY(10), .GAP_CYCLES(4), .ID_W(1)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id), .locked(locked)
  );

  uart_tx_sched #(.N_REQ(2), .START_DELAY(10), .GAP_CYCLES(0), .ID_W(1)) dutz (
    .clk(clk), .rstn(rstn), .req_valid(zvalid), .req_data(zdata),
    .req_last(zlast), .req_ready(zready), .tx_data(ztx_data),
    .tx_start(zstart), .tx_busy(zbusy), .grant_id(zgrant), .locked(zlocked)
  );

  // uart_tx stand-ins: busy from the cycle after tx_start for 20 cycles
  int bcnt = 0, zbcnt = 0;
  always @(posedge clk) begin
    if (!rstn)           bcnt <= 0;
    else if (tx_start)   bcnt <= 20;
    else if (bcnt != 0)  bcnt <= bcnt - 1;
    if (!rstn)           zbcnt <= 0;
    else if (zstart)     zbcnt <= 20;
    else if (zbcnt != 0) zbcnt <= zbcnt - 1;
  end
  assign tx_busy = (bcnt != 0);
  assign zbusy   = (zbcnt != 0);

  int   ecount = 0, fall_edge = 0, start_edge = 0, r1_cnt = 0;
  logic bprev = 1'b0;
  always @(posedge clk) begin
    ecount <= ecount + 1;
    bprev  <= tx_busy;
    if (bprev && !tx_busy) fall_edge <= ecount;
    if (tx_start) start_edge <= ecount;
  end
  always @(negedge clk) if (req_ready[1]) r1_cnt <= r1_cnt + 1;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    step();
    check({tag, "_rst_start"},  32'(tx_start),  32'd0);
    check({tag, "_rst_locked"}, 32'(locked),    32'd0);
    check({tag, "_rst_grant"},  32'(grant_id),  32'd0);
    check({tag, "_rst_ready"},  32'(req_ready), 32'd0);
    check({tag, "_rst_data"},   32'(tx_data),   32'd0);
    rstn = 1'b1;
  endtask

  task automatic check_startup(input string tag, input logic [1:0] exp);
    int bad = 0;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (req_ready != 2'b00) bad++;
      step();
    end
    check({tag, "_hold"}, 32'(bad), 32'd0);
    check({tag, "_rdy"},  32'(req_ready), 32'(exp));
  endtask

  task automatic xfer(input string tag, input int idx, input logic [7:0] d,
                      input logic lk, input bit chk_gap);
    int n = 0;
    #1;
    while (req_ready == 2'b00 && n < 500) begin
      step();
      n++;
    end
    check({tag, "_wait"},   32'(n < 500), 32'd1);
    check({tag, "_rdy"},    32'(req_ready), 32'(1) << idx);
    step();
    check({tag, "_start"},  32'(tx_start), 32'd1);
    check({tag, "_data"},   32'(tx_data),  32'(d));
    check({tag, "_grant"},  32'(grant_id), 32'(idx));
    check({tag, "_locked"}, 32'(locked),   32'(lk));
    step();
    check({tag, "_pulse"},  32'(tx_start), 32'd0);
    if (chk_gap) check({tag, "_gap"}, 32'(start_edge - fall_edge), 32'd6);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int snap, n;
    repeat (3) step();

    // Startup hold: single requester 0
    req_valid = 2'b01; req_last = 2'b01; req_data = 16'h00A5;
    do_reset("t1");
    check_startup("t1", 2'b01);
    xfer("t1b0", 0, 8'hA5, 1'b0, 1'b0);
    req_valid = 2'b00;

    // Round-robin with single-byte packets
    req_valid = 2'b11; req_last = 2'b11; req_data = 16'h2110;
    do_reset("t2");
    check_startup("t2", 2'b01);
    xfer("t2b0", 0, 8'h10, 1'b0, 1'b0);
    xfer("t2b1", 1, 8'h21, 1'b0, 1'b1);
    xfer("t2b2", 0, 8'h10, 1'b0, 1'b1);
    xfer("t2b3", 1, 8'h21, 1'b0, 1'b1);

    // Packet lock: 41 42 43 from req0 while req1 waits
    req_valid = 2'b11; req_last = 2'b10; req_data = 16'h9941;
    do_reset("t3");
    check_startup("t3", 2'b01);
    snap = r1_cnt;
    xfer("t3b0", 0, 8'h41, 1'b1, 1'b0);
    req_data[7:0] = 8'h42;
    xfer("t3b1", 0, 8'h42, 1'b1, 1'b1);
    req_data[7:0] = 8'h43; req_last = 2'b11;
    xfer("t3b2", 0, 8'h43, 1'b0, 1'b1);
    req_valid = 2'b10;
    check("t3_r1_blocked", 32'(r1_cnt - snap), 32'd0);
    xfer("t3b3", 1, 8'h99, 1'b0, 1'b1);

    // Owner stall: req0 locked then idle for 50 cycles
    req_valid = 2'b11; req_last = 2'b00; req_data = 16'h6150;
    do_reset("t4");
    check_startup("t4", 2'b01);
    xfer("t4b0", 0, 8'h50, 1'b1, 1'b0);
    req_valid = 2'b10;
    snap = r1_cnt;
    repeat (50) step();
    check("t4_r1_blocked", 32'(r1_cnt - snap), 32'd0);
    check("t4_ready",      32'(req_ready), 32'd0);
    check("t4_locked",     32'(locked), 32'd1);
    req_valid = 2'b11; req_last = 2'b01; req_data[7:0] = 8'h51;
    xfer("t4b1", 0, 8'h51, 1'b0, 1'b0);
    req_valid = 2'b10;
    xfer("t4b2", 1, 8'h61, 1'b1, 1'b1);

    // Reset while uart_tx is busy with grant 1 locked
    repeat (3) step();
    check("t5_busy", 32'(tx_busy), 32'd1);
    do_reset("t5");
    check_startup("t5", 2'b10);

    // Zero-gap build: ready returns the cycle after busy falls
    zvalid = 2'b10; zlast = 2'b11; zdata = 16'hC300;
    n = 0;
    #1;
    while (zready == 2'b00 && n < 500) begin step(); n++; end
    check("t6_wait",  32'(n < 500), 32'd1);
    check("t6_rdy0",  32'(zready), 32'd2);
    step();
    check("t6_start0", 32'(zstart), 32'd1);
    check("t6_data0",  32'(ztx_data), 32'hC3);
    n = 0;
    while (!zbusy && n < 100) begin step(); n++; end
    while (zbusy && n < 100) begin step(); n++; end
    check("t6_fall",      32'(n < 100), 32'd1);
    check("t6_rdy_fall",  32'(zready), 32'd0);
    zdata = 16'hC400;
    step();
    check("t6_rdy_next",  32'(zready), 32'd2);
    step();
    check("t6_start1", 32'(zstart), 32'd1);
    check("t6_data1",  32'(ztx_data), 32'hC4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
